// File: rtl/sram_like_arbiter_pkg.sv
// Shared definitions for the SRAM-like request arbiter: FSM state encoding
// and the channel-id width helper.
package sram_like_arbiter_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  // A single channel still needs a one-bit id so the order FIFO has a width.
  function automatic int id_width(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/sram_order_fifo.sv
// Order FIFO recording which channel owns each accepted-but-unanswered request,
// so responses are routed back in acceptance order.
module sram_order_fifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  // Explicit wrap keeps non-power-of-two depths correct.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem_q[rd_ptr_q];

  always_comb begin
    // NOTE: every output gets a default first so no latch is inferred.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is not reset; count/pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/sram_like_arbiter.sv
// Round-robin arbiter multiplexing several SRAM-like channels onto one master
// port, with in-order response routing through an order FIFO.
module sram_like_arbiter
  import sram_like_arbiter_pkg::*;
#(
  parameter int NUM_CH    = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int OUT_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic [NUM_CH-1:0]          ch_req,
  input  logic [NUM_CH-1:0]          ch_wr,
  input  logic [2*NUM_CH-1:0]        ch_size,
  input  logic [NUM_CH*DATA_W/8-1:0] ch_wstrb,
  input  logic [NUM_CH*ADDR_W-1:0]   ch_addr,
  input  logic [NUM_CH*DATA_W-1:0]   ch_wdata,
  output logic [NUM_CH-1:0]          ch_addr_ok,
  output logic [NUM_CH-1:0]          ch_data_ok,
  output logic [DATA_W-1:0]          ch_rdata,
  output logic                       m_req,
  output logic                       m_wr,
  output logic [1:0]                 m_size,
  output logic [DATA_W/8-1:0]        m_wstrb,
  output logic [ADDR_W-1:0]          m_addr,
  output logic [DATA_W-1:0]          m_wdata,
  input  logic                       m_addr_ok,
  input  logic                       m_data_ok,
  input  logic [DATA_W-1:0]          m_rdata,
  output logic                       err
);

  localparam int ID_W   = id_width(NUM_CH);
  localparam int STRB_W = DATA_W / 8;

  logic [0:0]      state_q, state_d;
  logic [ID_W-1:0] grant_q, grant_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic            err_q, err_d;

  logic [ID_W-1:0] sel_id, cand;
  logic            sel_found;
  logic            push, pop;
  logic            fifo_full, fifo_empty;
  logic [ID_W-1:0] fifo_head;

  // First requesting channel at or after rr_ptr, wrapping around.
  always_comb begin
    sel_found = 1'b0;
    sel_id    = '0;
    cand      = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      cand = ID_W'((int'(rr_ptr_q) + k) % NUM_CH);
      if (!sel_found && ch_req[cand]) begin
        sel_found = 1'b1;
        sel_id    = cand;
      end
    end
  end

  // Grant uses the registered full flag, so a same-cycle pop cannot free a slot.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    push     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sel_found && !fifo_full) begin
          grant_d = sel_id;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (m_addr_ok) begin
          push     = 1'b1;
          rr_ptr_d = (grant_q == ID_W'(NUM_CH - 1)) ? '0 : grant_q + ID_W'(1);
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign pop   = m_data_ok && !fifo_empty;
  assign err_d = err_q | (m_data_ok & fifo_empty);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      err_q    <= err_d;
    end
  end

  sram_order_fifo #(
    .WIDTH (ID_W),
    .DEPTH (OUT_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (push),
    .din    (grant_q),
    .pop    (pop),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .head   (fifo_head)
  );

  assign m_req   = (state_q == ST_HOLD);
  assign m_wr    = ch_wr[grant_q];
  assign m_size  = ch_size[grant_q*2 +: 2];
  assign m_wstrb = ch_wstrb[grant_q*STRB_W +: STRB_W];
  assign m_addr  = ch_addr[grant_q*ADDR_W +: ADDR_W];
  assign m_wdata = ch_wdata[grant_q*DATA_W +: DATA_W];

  always_comb begin
    ch_addr_ok = '0;
    ch_data_ok = '0;
    if (m_req) ch_addr_ok[grant_q] = m_addr_ok;
    if (pop)   ch_data_ok[fifo_head] = 1'b1;
  end

  assign ch_rdata = m_rdata;
  assign err      = err_q;

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Bench for sram_like_arbiter: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_sram_like_arbiter;

  localparam int NUM_CH    = 2;
  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 32;
  localparam int OUT_DEPTH = 4;
  localparam int STRB_W    = DATA_W / 8;

  logic                       clk = 1'b0;
  logic                       resetn;
  logic [NUM_CH-1:0]          ch_req, ch_wr;
  logic [2*NUM_CH-1:0]        ch_size;
  logic [NUM_CH*STRB_W-1:0]   ch_wstrb;
  logic [NUM_CH*ADDR_W-1:0]   ch_addr;
  logic [NUM_CH*DATA_W-1:0]   ch_wdata;
  logic [NUM_CH-1:0]          ch_addr_ok, ch_data_ok;
  logic [DATA_W-1:0]          ch_rdata;
  logic                       m_req, m_wr;
  logic [1:0]                 m_size;
  logic [STRB_W-1:0]          m_wstrb;
  logic [ADDR_W-1:0]          m_addr;
  logic [DATA_W-1:0]          m_wdata;
  logic                       m_addr_ok, m_data_ok;
  logic [DATA_W-1:0]          m_rdata;
  logic                       err;

  int errors = 0;
  int checks = 0;

  // Reference model: outstanding owners in acceptance order, the channel
  // currently presented on the master port (-1 = none), round-robin start, err.
  int mq[$];
  int cur = -1;
  int rr = 0;
  bit merr = 1'b0;
  logic [NUM_CH-1:0] last_ok = '0;

  sram_like_arbiter #(
    .NUM_CH    (NUM_CH),
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .OUT_DEPTH (OUT_DEPTH)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .ch_req     (ch_req),
    .ch_wr      (ch_wr),
    .ch_size    (ch_size),
    .ch_wstrb   (ch_wstrb),
    .ch_addr    (ch_addr),
    .ch_wdata   (ch_wdata),
    .ch_addr_ok (ch_addr_ok),
    .ch_data_ok (ch_data_ok),
    .ch_rdata   (ch_rdata),
    .m_req      (m_req),
    .m_wr       (m_wr),
    .m_size     (m_size),
    .m_wstrb    (m_wstrb),
    .m_addr     (m_addr),
    .m_wdata    (m_wdata),
    .m_addr_ok  (m_addr_ok),
    .m_data_ok  (m_data_ok),
    .m_rdata    (m_rdata),
    .err        (err)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, required finished", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, then advance the model across the next edge.
  initial forever begin
    @(negedge clk);
    if (!resetn) begin
      mq.delete();
      cur     = -1;
      rr      = 0;
      merr    = 1'b0;
      last_ok = '0;
    end else begin
      logic [NUM_CH-1:0] e_aok, e_dok;
      int nxt, size0;
      e_aok = '0;
      e_dok = '0;
      if (cur >= 0 && m_addr_ok) e_aok[cur] = 1'b1;
      if (m_data_ok && mq.size() > 0) e_dok[mq[0]] = 1'b1;
      check("model m_req", m_req, cur >= 0);
      if (cur >= 0) begin
        check("model m_wr", m_wr, ch_wr[cur]);
        check("model m_size", m_size, ch_size[cur*2 +: 2]);
        check("model m_wstrb", m_wstrb, ch_wstrb[cur*STRB_W +: STRB_W]);
        check("model m_addr", m_addr, ch_addr[cur*ADDR_W +: ADDR_W]);
        check("model m_wdata", m_wdata, ch_wdata[cur*DATA_W +: DATA_W]);
      end
      check("model ch_addr_ok", ch_addr_ok, e_aok);
      check("model ch_data_ok", ch_data_ok, e_dok);
      check("model err", err, merr);
      check("model ch_rdata", ch_rdata, m_rdata);
      last_ok = ch_addr_ok;

      size0 = mq.size();
      nxt   = cur;
      if (cur >= 0) begin
        if (m_addr_ok) nxt = -1;
      end else if (ch_req != '0 && size0 < OUT_DEPTH) begin
        for (int k = 0; k < NUM_CH; k++) begin
          if (ch_req[(rr + k) % NUM_CH]) begin
            nxt = (rr + k) % NUM_CH;
            break;
          end
        end
      end
      if (m_data_ok) begin
        if (size0 > 0) void'(mq.pop_front());
        else merr = 1'b1;
      end
      if (cur >= 0 && m_addr_ok) begin
        mq.push_back(cur);
        rr = (cur + 1) % NUM_CH;
      end
      cur = nxt;
    end
  end

  // Advance one cycle; a channel drops its request once it has been accepted.
  task automatic tick();
    @(posedge clk);
    #1;
    ch_req = ch_req & ~last_ok;
  endtask

  task automatic set_ch(input int c, input logic wr, input logic [1:0] sz,
                        input logic [STRB_W-1:0] st, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] d);
    ch_wr[c]                   = wr;
    ch_size[c*2 +: 2]          = sz;
    ch_wstrb[c*STRB_W +: STRB_W] = st;
    ch_addr[c*ADDR_W +: ADDR_W]  = a;
    ch_wdata[c*DATA_W +: DATA_W] = d;
    ch_req[c]                  = 1'b1;
  endtask

  task automatic wait_accept(input int c);
    int n;
    n = 0;
    while (ch_req[c] && n < 20) begin
      tick();
      n++;
    end
    check($sformatf("accept ch%0d within budget", c), ch_req[c], 1'b0);
  endtask

  initial begin
    resetn    = 1'b0;
    ch_req    = '0;
    ch_wr     = '0;
    ch_size   = '0;
    ch_wstrb  = '0;
    ch_addr   = '0;
    ch_wdata  = '0;
    m_addr_ok = 1'b0;
    m_data_ok = 1'b0;
    m_rdata   = '0;

    #1;
    check("reset m_req", m_req, 1'b0);
    check("reset ch_addr_ok", ch_addr_ok, 2'b00);
    check("reset ch_data_ok", ch_data_ok, 2'b00);
    check("reset err", err, 1'b0);
    repeat (2) @(posedge clk);
    #1;

    // Both channels request together out of reset, m_addr_ok tied high.
    set_ch(0, 1'b0, 2'd2, 4'hF, 32'h1000_0000, 32'h0);
    set_ch(1, 1'b1, 2'd2, 4'hF, 32'h2000_0004, 32'hDEAD_BEEF);
    m_addr_ok = 1'b1;
    resetn    = 1'b1;
    @(negedge clk);
    check("rr cycle0 m_req", m_req, 1'b0);
    tick();
    @(negedge clk);
    check("rr cycle1 m_req", m_req, 1'b1);
    check("rr cycle1 m_addr", m_addr, 32'h1000_0000);
    check("rr cycle1 ch_addr_ok", ch_addr_ok, 2'b01);
    tick();
    @(negedge clk);
    check("rr cycle2 m_req", m_req, 1'b0);
    tick();
    @(negedge clk);
    check("rr cycle3 m_req", m_req, 1'b1);
    check("rr cycle3 m_addr", m_addr, 32'h2000_0004);
    check("rr cycle3 m_wr", m_wr, 1'b1);
    check("rr cycle3 ch_addr_ok", ch_addr_ok, 2'b10);
    tick();
    m_data_ok = 1'b1;
    m_rdata   = 32'h1111_0000;
    @(negedge clk);
    check("rr drain first owner", ch_data_ok, 2'b01);
    tick();
    m_rdata = 32'h2222_0000;
    @(negedge clk);
    check("rr drain second owner", ch_data_ok, 2'b10);
    tick();
    m_data_ok = 1'b0;

    // Fill all outstanding slots; the fifth request waits until a response pops.
    for (int i = 0; i < OUT_DEPTH; i++) begin
      set_ch(0, 1'b0, 2'd2, 4'hF, 32'h3000_0000 + 32'(i * 4), 32'h0);
      wait_accept(0);
    end
    set_ch(0, 1'b0, 2'd2, 4'hF, 32'h3000_0010, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("full blocks grant", m_req, 1'b0);
      tick();
    end
    m_data_ok = 1'b1;
    m_rdata   = 32'h3333_0000;
    @(negedge clk);
    check("full pop ch_data_ok", ch_data_ok, 2'b01);
    check("no grant in pop cycle", m_req, 1'b0);
    tick();
    m_data_ok = 1'b0;
    @(negedge clk);
    check("grant cycle after pop", m_req, 1'b0);
    tick();
    @(negedge clk);
    check("fifth request issued", m_req, 1'b1);
    check("fifth request addr", m_addr, 32'h3000_0010);
    tick();
    m_data_ok = 1'b1;
    for (int i = 0; i < OUT_DEPTH; i++) begin
      m_rdata = 32'h4000_0000 + 32'(i);
      @(negedge clk);
      check("drain four ch0", ch_data_ok, 2'b01);
      tick();
    end
    m_data_ok = 1'b0;

    // ch1 accepted before ch0: responses return in that order.
    set_ch(1, 1'b0, 2'd1, 4'h3, 32'h4000_0000, 32'h0);
    wait_accept(1);
    set_ch(0, 1'b0, 2'd0, 4'h1, 32'h4000_0100, 32'h0);
    wait_accept(0);
    m_data_ok = 1'b1;
    m_rdata   = 32'hAAAA_0001;
    @(negedge clk);
    check("order first ch_data_ok", ch_data_ok, 2'b10);
    check("order first ch_rdata", ch_rdata, 32'hAAAA_0001);
    tick();
    m_rdata = 32'h0000_BBBB;
    @(negedge clk);
    check("order second ch_data_ok", ch_data_ok, 2'b01);
    check("order second ch_rdata", ch_rdata, 32'h0000_BBBB);
    tick();
    m_data_ok = 1'b0;

    // Push and pop in the same cycle with two outstanding, across pointer wrap.
    set_ch(0, 1'b0, 2'd2, 4'hF, 32'h5000_0000, 32'h0);
    wait_accept(0);
    set_ch(1, 1'b0, 2'd2, 4'hF, 32'h5000_0004, 32'h0);
    wait_accept(1);
    set_ch(0, 1'b1, 2'd0, 4'h1, 32'h5000_0008, 32'hCAFE_00AB);
    tick();
    m_data_ok = 1'b1;
    m_rdata   = 32'h5555_0000;
    @(negedge clk);
    check("push+pop ch_addr_ok", ch_addr_ok, 2'b01);
    check("push+pop ch_data_ok", ch_data_ok, 2'b01);
    check("push+pop m_wstrb", m_wstrb, 4'h1);
    tick();
    @(negedge clk);
    check("after push+pop owner ch1", ch_data_ok, 2'b10);
    tick();
    @(negedge clk);
    check("after push+pop owner ch0", ch_data_ok, 2'b01);
    tick();
    m_data_ok = 1'b0;
    @(negedge clk);
    check("push+pop no stray err", err, 1'b0);

    // Stray response with nothing outstanding.
    tick();
    m_data_ok = 1'b1;
    @(negedge clk);
    check("stray ch_data_ok", ch_data_ok, 2'b00);
    tick();
    m_data_ok = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("err sticky", err, 1'b1);
      tick();
    end

    // Reset while holding a request with three outstanding.
    set_ch(0, 1'b0, 2'd2, 4'hF, 32'h6000_0000, 32'h0);
    wait_accept(0);
    set_ch(1, 1'b0, 2'd2, 4'hF, 32'h6000_0004, 32'h0);
    wait_accept(1);
    set_ch(0, 1'b0, 2'd2, 4'hF, 32'h6000_0008, 32'h0);
    wait_accept(0);
    m_addr_ok = 1'b0;
    set_ch(1, 1'b0, 2'd2, 4'hF, 32'h6000_000C, 32'h0);
    tick();
    @(negedge clk);
    check("hold before reset m_req", m_req, 1'b1);
    @(posedge clk);
    #2;
    resetn = 1'b0;
    ch_req = '0;
    #1;
    check("async reset m_req", m_req, 1'b0);
    check("async reset ch_addr_ok", ch_addr_ok, 2'b00);
    check("async reset err", err, 1'b0);
    tick();
    tick();
    resetn    = 1'b1;
    m_addr_ok = 1'b1;
    @(negedge clk);
    check("post reset idle", m_req, 1'b0);
    tick();
    m_data_ok = 1'b1;
    @(negedge clk);
    check("post reset stray ch_data_ok", ch_data_ok, 2'b00);
    tick();
    m_data_ok = 1'b0;
    @(negedge clk);
    check("post reset stray err", err, 1'b1);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sram_like_arbiter.md
SRAM_LIKE_ARBITER -- requirements
Module: sram_like_arbiter

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, meaning number of requesting channels (ch0 = inst fetch, ch1 = data).
REQ-002 SHALL have parameter ADDR_W, default 32, meaning address width.
REQ-003 SHALL have parameter DATA_W, default 32, meaning data width; strobe width = DATA_W/8.
REQ-004 SHALL have parameter OUT_DEPTH, default 4, meaning maximum outstanding accepted-but-unanswered requests.
REQ-005 SHALL have port clk  in  1  single clock, rising edge.
REQ-006 SHALL have port resetn  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port ch_req  in  NUM_CH  per-channel request.
REQ-008 SHALL have port ch_wr  in  NUM_CH  per-channel write flag.
REQ-009 SHALL have port ch_size  in  2*NUM_CH  per-channel size (0 = byte, 1 = half, 2 = word).
REQ-010 SHALL have port ch_wstrb  in  NUM_CH*DATA_W/8  per-channel byte strobes.
REQ-011 SHALL have port ch_addr  in  NUM_CH*ADDR_W  per-channel address.
REQ-012 SHALL have port ch_wdata  in  NUM_CH*DATA_W  per-channel write data.
REQ-013 SHALL have port ch_addr_ok  out  NUM_CH  per-channel request accepted.
REQ-014 SHALL have port ch_data_ok  out  NUM_CH  per-channel response valid.
REQ-015 SHALL have port ch_rdata  out  DATA_W  response data, broadcast to all channels.
REQ-016 SHALL have ports m_req/m_wr/m_size/m_wstrb/m_addr/m_wdata  out  1/1/2/DATA_W/8/ADDR_W/DATA_W  SRAM-like master request.
REQ-017 SHALL have ports m_addr_ok, m_data_ok  in  1 each, and m_rdata  in  DATA_W  SRAM-like master response.
REQ-018 SHALL have port err  out  1  sticky flag: m_data_ok received with no outstanding request.

Function
REQ-019 SHALL implement a two-state FSM: IDLE and HOLD.
REQ-020 In IDLE with any ch_req set and fewer than OUT_DEPTH outstanding, SHALL register grant = first requesting channel at or after rr_ptr (round-robin) and go to HOLD; otherwise SHALL stay in IDLE.
REQ-021 In IDLE with OUT_DEPTH outstanding, SHALL not grant, even if a pop occurs that cycle.
REQ-022 In HOLD, m_req SHALL be 1 and m_wr/m_size/m_wstrb/m_addr/m_wdata SHALL be muxed from the granted channel; in IDLE, m_req SHALL be 0.
REQ-023 ch_addr_ok[grant] SHALL equal m_addr_ok in HOLD; all other ch_addr_ok bits SHALL be 0.
REQ-024 On m_req & m_addr_ok, the FSM SHALL push the grant id into the order FIFO, set rr_ptr = grant+1 (mod NUM_CH), and return to IDLE.
REQ-025 Issue rate SHALL be at most one request per 2 cycles; request latency from ch_req to m_req SHALL be 1 cycle.
REQ-026 Channels SHALL hold ch_req and fields stable until ch_addr_ok; the block does not re-sample them in HOLD.
REQ-027 ch_data_ok[i] SHALL equal m_data_ok & FIFO non-empty & head==i; the head SHALL pop on that event.
REQ-028 Responses SHALL be routed strictly in acceptance order.
REQ-029 A simultaneous push and pop SHALL leave the count unchanged; pointers SHALL wrap modulo OUT_DEPTH.
REQ-030 m_data_ok with an empty FIFO SHALL assert no ch_data_ok and SHALL set err until reset.
REQ-031 ch_rdata SHALL equal m_rdata combinationally.

Reset
REQ-032 On resetn low, asynchronously: state=IDLE, grant=0, rr_ptr=0, FIFO pointers/count=0, err=0; hence m_req=0 and all ch_addr_ok/ch_data_ok=0.
REQ-033 On reset mid-operation, outstanding entries SHALL be discarded; a later stray m_data_ok SHALL set err.

Structure
REQ-034 A shared package SHALL hold the FSM state encoding and the ID-width function clog2(NUM_CH) (minimum 1).
REQ-035 The order FIFO SHALL be a sub-module sram_order_fifo (parameters WIDTH, DEPTH; push, pop, full, empty, head).
REQ-036 The FIFO SHALL use the same async active-low reset.

Verification
REQ-037 ch0 and ch1 request together from reset, m_addr_ok tied 1 -> m_req carries ch0 at cycle 1, then ch1 at cycle 3.
REQ-038 Issue 4 ch0 reads with m_data_ok held 0 -> 4 accepted, 5th held in IDLE; one m_data_ok -> grant occurs the cycle after the pop.
REQ-039 Accept ch1 then ch0, return rdata 0xAAAA0001 then 0x0000BBBB -> ch_data_ok[1] fires with 0xAAAA0001 first, then ch_data_ok[0] with 0x0000BBBB.
REQ-040 Push and pop in the same cycle with count=2 -> count stays 2, order preserved across pointer wrap.
REQ-041 m_data_ok pulse with FIFO empty -> no ch_data_ok, err=1 held until resetn low.
REQ-042 Drop resetn in HOLD with 3 outstanding -> m_req=0 immediately and count=0; a later m_data_ok sets err.
